sr_cmd_conditioner: RTL
=======================

SR_CMD_CONDITIONER -- requirements
Module: sr_cmd_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the consecutive stable synchronized samples needed to accept a level change (legal range 2..1024).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth per raw input (legal range 2..3).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port set_btn, input, 1, raw asynchronous bouncing set request.
REQ-006 SHALL have port clr_btn, input, 1, raw asynchronous bouncing reset request.
REQ-007 SHALL have port S, output, 1, one-cycle set pulse to the downstream SR latch S input.
REQ-008 SHALL have port R, output, 1, one-cycle reset pulse to the downstream SR latch R input.
REQ-009 SHALL have port conflict, output, 1, one-cycle flag: a set pulse was suppressed.
REQ-010 SHALL have port set_lvl, output, 1, debounced level of set_btn.
REQ-011 SHALL have port clr_lvl, output, 1, debounced level of clr_btn.

Function
REQ-012 Each raw input SHALL pass through a SYNC_STAGES flop chain before any other logic.
REQ-013 Each channel SHALL run a 4-state FSM: LOW, QUAL_HIGH, HIGH, QUAL_LOW. The encoded level is 1 in HIGH and QUAL_LOW.
REQ-014 LOW -> QUAL_HIGH on a synchronized 1; QUAL_HIGH -> LOW on a synchronized 0 (counter cleared); QUAL_HIGH -> HIGH when the count reaches DEBOUNCE_CYCLES. HIGH/QUAL_LOW are symmetric.
REQ-015 The count SHALL be of consecutive synchronized samples differing from the current level. Width: clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.
REQ-016 A LOW->HIGH transition SHALL produce exactly one rising-edge pulse in the cycle the level first reads 1. A HIGH->LOW transition SHALL produce no pulse.
REQ-017 Latency: if the raw input rises before edge 0 and stays, the level and pulse SHALL first be 1 after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL cause no level change and no pulse.
REQ-019 S SHALL equal the set-channel pulse and R SHALL equal the clear-channel pulse, except as stated in REQ-020.
REQ-020 When both pulses occur in the same cycle, the outputs SHALL be R=1, S=0, conflict=1. The set event is dropped, not deferred.
REQ-021 S and R SHALL never both be 1 in any cycle, including the first cycle after reset.
REQ-022 S, R, conflict, set_lvl and clr_lvl SHALL all be registered outputs with no combinational path from the raw inputs.
REQ-023 Holding a button indefinitely SHALL yield exactly one pulse. A new pulse SHALL require a debounced release followed by a debounced press.

Reset
REQ-024 While rst=1 at a clock edge, the sync flops, FSMs (LOW), counters and all outputs SHALL be cleared to 0.
REQ-025 Reset asserted mid-qualification SHALL discard the partial count. A button held through reset SHALL be re-qualified from zero after reset release and then pulse once.
REQ-026 No pulse SHALL be emitted in the cycle rst deasserts.

Structure
REQ-027 Package sr_cmd_pkg SHALL hold the FSM state encoding (LOW, QUAL_HIGH, HIGH, QUAL_LOW), the default DEBOUNCE_CYCLES and SYNC_STAGES, and a counter-width function.
REQ-028 Sub-module debounce_channel SHALL contain the synchronizer, FSM, counter and edge pulse for one input, instantiated twice.
REQ-029 The top level SHALL contain only the two channel instances, the conflict arbiter and the output registers.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Clean press: set_btn 0->1 before edge 0 and held -> S=1 only after edge 5; set_lvl=1 from edge 5; R=0 throughout.
REQ-031 Bounce: clr_btn toggles 1,0,1,0 on successive edges, then is held 1 -> no R pulse during the toggling; exactly one R pulse, 5 edges after the final rise.
REQ-032 Simultaneous press: set_btn and clr_btn rise before the same edge -> R=1, S=0, conflict=1 in one cycle; never S=R=1.
REQ-033 Reset mid-qualification: set_btn held, rst=1 at edge 3 for one cycle -> no S pulse at edge 5; S pulse 6 edges after rst falls.
REQ-034 Hold/release: set_btn held 50 cycles, released 10 cycles, pressed again -> exactly two S pulses, set_lvl falling 5 edges after release.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// ============================================================================
// Module  : sr_cmd_pkg
// Purpose : Shared definitions for the SR latch command conditioner. Holds the
//           debounce FSM state encoding, the default timing parameters and the
//           helper that sizes the debounce qualification counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_cmd_pkg;

    // Default number of consecutive stable synchronized samples required to
    // accept a level change on a button input.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Default synchronizer depth per raw asynchronous input.
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Debounce FSM states. Bit 1 of the encoding is the accepted level,
    // so HIGH and QUAL_LOW both read as 1.
    typedef enum logic [1:0] {
        LOW       = 2'b00,
        QUAL_HIGH = 2'b01,
        HIGH      = 2'b11,
        QUAL_LOW  = 2'b10
    } deb_state_e;

    // Width of a counter that must hold values 0..cycles without wrapping.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : sr_cmd_pkg

`default_nettype wire

// File: rtl/sr_cmd_conditioner_debounce_channel.sv
// ============================================================================
// Module  : debounce_channel
// Purpose : One button channel: SYNC_STAGES-deep synchronizer, 4-state
//           debounce FSM with a saturating qualification counter, and rising
//           edge detection of the debounced level.
//
//           The channel publishes the *next* debounced level and the *next*
//           rising-edge pulse. The parent registers both in its output flops,
//           so the externally visible level and pulse change on the same
//           clock edge as the FSM enters HIGH, with no extra cycle of latency
//           and no combinational path from the raw pin to any output.
//
// Ports   : clk         - clock, rising edge
//           rst         - synchronous active-high reset
//           raw_i       - raw asynchronous bouncing button input
//           level_d_o   - next-cycle debounced level
//           rise_d_o    - next-cycle one-shot pulse on LOW->HIGH acceptance
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_d_o,
    output logic rise_d_o
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    // The sample that brings the run length to DEBOUNCE_CYCLES is the one
    // that arrives while the counter already holds DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // Synchronizer: raw input enters bit 0, synchronized sample leaves the
    // top bit. Nothing else looks at raw_i.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM and counter
    // ------------------------------------------------------------------
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] cnt_inc;

    // Saturating increment; the FSM normally leaves qualification before the
    // counter gets near its maximum, but it must never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            LOW: begin
                if (sample) begin
                    // First differing sample counts as one.
                    state_d = QUAL_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end

            QUAL_HIGH: begin
                if (!sample) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end

            HIGH: begin
                if (!sample) begin
                    state_d = QUAL_LOW;
                    cnt_d   = CNT_ONE;
                end
            end

            QUAL_LOW: begin
                if (sample) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end

            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-cycle level and press pulse. Only an accepted press produces a
    // pulse; accepting a release does not.
    // ------------------------------------------------------------------
    assign level_d_o = (state_d == HIGH) || (state_d == QUAL_LOW);
    assign rise_d_o  = (state_q == QUAL_HIGH) && (state_d == HIGH);

endmodule : debounce_channel

`default_nettype wire

// File: rtl/sr_cmd_conditioner.sv
// ============================================================================
// Module  : sr_cmd_conditioner
// Purpose : Turns two raw bouncing push-buttons into clean one-cycle set and
//           reset pulses for a downstream SR latch. Each button is
//           synchronized and debounced independently; when both pulses land
//           in the same cycle the reset wins, the set is dropped and a
//           one-cycle conflict flag is raised, so S and R are never high
//           together.
//
// Ports   : clk      - clock, rising edge
//           rst      - synchronous active-high reset
//           set_btn  - raw asynchronous set button
//           clr_btn  - raw asynchronous clear button
//           S        - one-cycle set pulse (registered)
//           R        - one-cycle reset pulse (registered)
//           conflict - one-cycle flag: a set pulse was suppressed (registered)
//           set_lvl  - debounced set_btn level (registered)
//           clr_lvl  - debounced clr_btn level (registered)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_cmd_conditioner
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic conflict,
    output logic set_lvl,
    output logic clr_lvl
);

    logic set_level_d, set_rise_d;
    logic clr_level_d, clr_rise_d;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_set_ch (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (set_btn),
        .level_d_o (set_level_d),
        .rise_d_o  (set_rise_d)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_clr_ch (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (clr_btn),
        .level_d_o (clr_level_d),
        .rise_d_o  (clr_rise_d)
    );

    // ------------------------------------------------------------------
    // Conflict arbiter: clear has priority. A colliding set is discarded
    // outright rather than queued for a later cycle.
    // ------------------------------------------------------------------
    logic s_d, r_d, conflict_d;

    always_comb begin
        r_d        = clr_rise_d;
        s_d        = set_rise_d & ~clr_rise_d;
        conflict_d = set_rise_d &  clr_rise_d;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic s_q, r_q, conflict_q, set_lvl_q, clr_lvl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            set_lvl_q  <= 1'b0;
            clr_lvl_q  <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            set_lvl_q  <= set_level_d;
            clr_lvl_q  <= clr_level_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;
    assign set_lvl  = set_lvl_q;
    assign clr_lvl  = clr_lvl_q;

endmodule : sr_cmd_conditioner

`default_nettype wire
